// File: rtl/led_arbiter_pkg.sv
// Shared constants for the LED arbiter: pattern codes, per-phase masks and FSM encoding.
package led_arbiter_pkg;

  localparam int FRAME_TICKS = 8;

  localparam logic [1:0] PAT_ON     = 2'b00;
  localparam logic [1:0] PAT_SLOW   = 2'b01;
  localparam logic [1:0] PAT_FAST   = 2'b10;
  localparam logic [1:0] PAT_DOUBLE = 2'b11;

  // Bit n of each mask is the LED value during phase n (phase 0 is the LSB).
  localparam logic [7:0] MASK_ON     = 8'b1111_1111;
  localparam logic [7:0] MASK_SLOW   = 8'b0000_1111;
  localparam logic [7:0] MASK_FAST   = 8'b0101_0101;
  localparam logic [7:0] MASK_DOUBLE = 8'b0000_0101;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  function automatic logic [7:0] pat_mask(input logic [1:0] code);
    case (code)
      PAT_ON:   pat_mask = MASK_ON;
      PAT_SLOW: pat_mask = MASK_SLOW;
      PAT_FAST: pat_mask = MASK_FAST;
      default:  pat_mask = MASK_DOUBLE;
    endcase
  endfunction

endpackage

// File: rtl/led_arbiter_rr.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module led_arbiter_rr #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic               valid
);

  int idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!valid && req[idx]) begin
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_arbiter.sv
// Round-robin sharing of one LED between NUM_REQ requesters, one 8-tick frame per grant.
// Optional LED_ARBITER_PWM_EN adds a 4-bit brightness input gating the LED with a PWM counter.
module led_arbiter
  import led_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int TICK_DIV = 6000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [2*NUM_REQ-1:0] pattern,
`ifdef LED_ARBITER_PWM_EN
  input  logic [3:0]           brightness,
`endif
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 led
);

  localparam int PTR_W = $clog2(NUM_REQ);

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [31:0]        presc_q, presc_d;
  logic [2:0]         phase_q, phase_d;
  logic [1:0]         pat_q, pat_d;
  logic               led_q, led_d;
  logic               led_bit;
  logic               tick, frame_end;
  logic [PTR_W-1:0]   owner_inc, pick_ptr, winner_idx;
  logic [NUM_REQ-1:0] winner;
  logic               winner_valid;
  logic [1:0]         winner_pat;
  logic [7:0]         cur_mask;

  assign tick      = (presc_q == 32'(TICK_DIV - 1));
  assign frame_end = (state_q == ST_ACTIVE) && (phase_q == 3'(FRAME_TICKS - 1)) && tick;
  assign owner_inc = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + PTR_W'(1);
  // While a frame runs, the only pick that matters is at frame_end, which starts after the owner.
  assign pick_ptr  = (state_q == ST_ACTIVE) ? owner_inc : rr_ptr_q;
  assign cur_mask  = pat_mask(pat_q);

  led_arbiter_rr #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rr (
    .req    (req),
    .ptr    (pick_ptr),
    .winner (winner),
    .valid  (winner_valid)
  );

  always_comb begin
    winner_idx = '0;
    winner_pat = 2'b00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner[i]) begin
        winner_idx = PTR_W'(i);
        winner_pat = pattern[2*i +: 2];
      end
    end
  end

`ifdef LED_ARBITER_PWM_EN
  logic [3:0] pwm_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_q <= 4'd0;
    else        pwm_q <= pwm_q + 4'd1;
  end
`endif

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    presc_d  = tick ? 32'd0 : presc_q + 32'd1;
    phase_d  = phase_q;
    pat_d    = pat_q;
    led_bit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (winner_valid) begin
          state_d = ST_ACTIVE;
          grant_d = winner;
          owner_d = winner_idx;
          pat_d   = winner_pat;
          presc_d = 32'd0;
          phase_d = 3'd0;
          led_bit = 1'b1;
        end
      end
      default: begin
        led_bit = cur_mask[phase_q];
        if (tick) phase_d = phase_q + 3'd1;
        if (frame_end) begin
          rr_ptr_d = owner_inc;
          if (winner_valid) begin
            grant_d = winner;
            owner_d = winner_idx;
            pat_d   = winner_pat;
          end else begin
            state_d = ST_IDLE;
            grant_d = '0;
            led_bit = 1'b0;
          end
        end
      end
    endcase
`ifdef LED_ARBITER_PWM_EN
    led_d = led_bit & (pwm_q < brightness);
`else
    led_d = led_bit;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      presc_q  <= 32'd0;
      phase_q  <= 3'd0;
      pat_q    <= 2'b00;
      led_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      presc_q  <= presc_d;
      phase_q  <= phase_d;
      pat_q    <= pat_d;
      led_q    <= led_d;
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q == ST_ACTIVE);
  assign led   = led_q;

endmodule

// File: doc/led_arbiter.md
Name: led_arbiter

Overview:
- Shares the single board LED between NUM_REQ requesters (e.g. heartbeat, error, CPU status).
- Each requester asks for one of four blink patterns.
- Round-robin arbitration at frame boundaries; the winner's pattern drives the LED for at least one full 8-tick frame.
- Top-level status block driven from the 48 MHz SB_HFOSC clock.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TICK_DIV, 6000000, clk cycles per pattern tick (8 ticks/s at 48 MHz); must be >= 2.

Ports:
- clk  input  1  system clock (48 MHz HFOSC).
- rst_n  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  per-requester LED request, level-sensitive.
- pattern  input  2*NUM_REQ  per-requester pattern code; bits [2i+1:2i] belong to requester i.
- grant  output  NUM_REQ  one-hot current owner; all-zero when idle.
- busy  output  1  high while ACTIVE.
- led  output  1  LED drive, active-high, registered.

Behaviour:
- Reset (async assert, sync-safe deassert into flop domain): led=0, grant=0, busy=0, state=IDLE, rr pointer=0, prescaler=0, phase=0.
- Prescaler:
  - Counts 0..TICK_DIV-1; tick pulses when it wraps.
  - Cleared on every new grant from IDLE.
  - 32-bit counter, unsigned compare.
- Phase: 3-bit counter, advances on tick, wraps 7->0. The cycle where phase==7 and tick is asserted is frame_end.
- Pattern codes, LED value per phase 0..7:
  - 00 ON: 11111111
  - 01 SLOW: 11110000 (1 Hz)
  - 10 FAST: 10101010 (4 Hz)
  - 11 DOUBLE: 10100000 (heartbeat)
- Pattern latching: the code is latched at grant time. Changes to the pattern input mid-frame are ignored until the next grant.
- FSM IDLE:
  - led=0.
  - If any req is high: pick the first set req at or after rr pointer (wrapping).
  - Next edge: grant=one-hot winner, busy=1, led=pattern bit for phase 0 (always 1), phase=0, prescaler=0, state -> ACTIVE.
  - Latency is one cycle from req to grant and led.
- FSM ACTIVE:
  - led=latched_pattern[phase], registered, updates on the edge after phase changes.
  - Owner deasserting req mid-frame has no effect; the frame always completes.
- At frame_end:
  - Set rr pointer to (owner+1) mod NUM_REQ and re-arbitrate from there.
  - If any req: grant the winner (may be the same owner if it is the only requester) and latch its pattern. Phase continues 7->0 with no gap cycle.
  - If no req: state -> IDLE, grant=0, busy=0, led=0.
- Simultaneous requests: strict round-robin. No requester waits more than NUM_REQ-1 frames.
- grant is always one-hot or zero. The output never glitches between owners mid-frame.
- Reset mid-frame: immediate return to reset values; the frame is not completed.

Optional Feature:
- LED_ARBITER_PWM_EN defined:
  - Adds input brightness [3:0] and a 4-bit free-running pwm counter (reset 0, increments every clk).
  - led = pattern_bit & (pwm_cnt < brightness).
  - brightness=0 gives LED off; 15 gives 15/16 duty.
  - brightness is sampled every cycle, not latched.
- Undefined: no brightness port, no pwm counter; led = pattern_bit.

Decomposition:
- Package led_arbiter_pkg:
  - Pattern code constants PAT_ON, PAT_SLOW, PAT_FAST, PAT_DOUBLE.
  - FRAME_TICKS=8.
  - 8-bit pattern mask constants.
  - FSM state encoding ST_IDLE/ST_ACTIVE.
- Sub-module led_arbiter_rr: combinational round-robin picker. Inputs req and pointer; outputs one-hot winner and valid.

Test Plan (TICK_DIV=2, NUM_REQ=4):
- Reset: hold rst_n=0 with req=4'b1111 -> led=0, grant=0, busy=0. Release -> grant=0001 and led=1 one cycle later.
- Single requester 0 with pattern=10 (FAST), held 3 frames -> led sequence 1,0,1,0,... changes every 2 clk. grant stays 0001 across frame_end with no idle gap.
- req=1111, all SLOW -> grants rotate 0001, 0010, 0100, 1000, 0001 at every 16-cycle frame_end. led is high for 8 cycles, low for 8 each frame.
- Requester 2 (DOUBLE) drops req at phase 3 -> led finishes 10100000 for that frame. At frame_end: grant=0, busy=0, led=0.
- Pattern input changed from 00 to 10 mid-frame -> led follows ON until frame_end. New code takes effect only on re-grant.
- PWM build: brightness=4, ON pattern -> led high exactly 4 of every 16 clk. brightness=0 -> led constant 0.
